arbitro_ula_logica: RTL

Two-channel round-robin arbiter and sequencer that shares one 8-bit logic unit (NOT/AND/OR/XOR/XNOR) between two requesters. Each channel presents operands and an operation code through a valid/ready request handshake. The granted operation runs on the shared unit, the 9-bit result is registered, and it is returned to the granted channel through a valid/ready response handshake. The block sits between the ALU front-end requesters and the logic datapath of the 8-bit ALU.

---
 rtl/ula_pkg.sv | 13 +
 rtl/comparador8bits.sv | 31 +++
 rtl/arbitro_ula_logica.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the logic-unit arbiter: widths, opcodes and FSM states.
package ula_pkg;
    localparam int LARG     = 8;
    localparam int LARG_RES = 9;

    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;

    typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;
endpackage

// File: rtl/comparador8bits.sv
// Shared 8-bit logic unit (NOT/AND/OR/XOR/XNOR); unsupported codes yield 0.
// o_erro exists only when ARBITRO_ULA_ERRO_OPCODE_EN is defined.
module comparador8bits
    import ula_pkg::*;
(
    input  logic [LARG-1:0]     i_a,
    input  logic [LARG-1:0]     i_b,
    input  logic [3:0]          i_codigo,
`ifdef ARBITRO_ULA_ERRO_OPCODE_EN
    output logic                o_erro,
`endif
    output logic [LARG_RES-1:0] o_resultado
);

    always_comb begin
        o_resultado = '0;
        case (i_codigo)
            OP_NOT:  o_resultado[LARG-1:0] = ~i_a;
            OP_AND:  o_resultado[LARG-1:0] = i_a & i_b;
            OP_OR:   o_resultado[LARG-1:0] = i_a | i_b;
            OP_XOR:  o_resultado[LARG-1:0] = i_a ^ i_b;
            OP_XNOR: o_resultado[LARG-1:0] = ~(i_a ^ i_b);
            default: o_resultado = '0;
        endcase
    end

`ifdef ARBITRO_ULA_ERRO_OPCODE_EN
    assign o_erro = !(i_codigo inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_XNOR});
`endif

endmodule

// File: rtl/arbitro_ula_logica.sv
// Two-channel round-robin arbiter sharing one logic unit; request/response handshakes.
// Optional macro ARBITRO_ULA_ERRO_OPCODE_EN enables the registered unsupported-code flag.
module arbitro_ula_logica
    import ula_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [LARG-1:0]     entradaA0,
    input  logic [LARG-1:0]     entradaB0,
    input  logic [LARG-1:0]     entradaA1,
    input  logic [LARG-1:0]     entradaB1,
    input  logic [3:0]          codigo0,
    input  logic [3:0]          codigo1,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [LARG_RES-1:0] resultado,
    output logic                resp_erro
);

    estado_t               r_estado, w_prox;
    logic                  r_ultimo;
    logic                  r_canal;
    logic [LARG-1:0]       r_a, r_b;
    logic [3:0]            r_cod;
    logic [LARG_RES-1:0]   r_resultado;
    logic [1:0]            w_grant;
    logic                  w_canal;
    logic [LARG-1:0]       w_a, w_b;
    logic [3:0]            w_cod;
    logic [LARG_RES-1:0]   w_res;

    // Under contention the channel that was not served last wins.
    always_comb begin
        w_grant = 2'b00;
        if (r_estado == OCIOSO) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ultimo ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_canal   = w_grant[1];
    assign w_a       = w_canal ? entradaA1 : entradaA0;
    assign w_b       = w_canal ? entradaB1 : entradaB0;
    assign w_cod     = w_canal ? codigo1   : codigo0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:   if (|req_valid) w_prox = EXECUTA;
            EXECUTA:  w_prox = RESPONDE;
            RESPONDE: if (resp_ready[r_canal]) w_prox = OCIOSO;
            default:  w_prox = OCIOSO;
        endcase
    end

    always_comb begin
        resp_valid = 2'b00;
        if (r_estado == RESPONDE) resp_valid[r_canal] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ultimo    <= 1'b1;
            r_canal     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cod       <= '0;
            r_resultado <= '0;
        end else begin
            if (|w_grant) begin
                r_ultimo <= w_canal;
                r_canal  <= w_canal;
                r_a      <= w_a;
                r_b      <= w_b;
                r_cod    <= w_cod;
            end
            if (r_estado == EXECUTA) r_resultado <= w_res;
        end
    end

    assign resultado = r_resultado;

`ifdef ARBITRO_ULA_ERRO_OPCODE_EN
    logic w_erro;
    logic r_erro;

    comparador8bits u_comparador (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_codigo    (r_cod),
        .o_erro      (w_erro),
        .o_resultado (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_erro <= 1'b0;
        else if (r_estado == EXECUTA)  r_erro <= w_erro;
    end

    assign resp_erro = r_erro;
`else
    comparador8bits u_comparador (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_codigo    (r_cod),
        .o_resultado (w_res)
    );

    assign resp_erro = 1'b0;
`endif

endmodule
